cache_mem_arbiter: RTL and testbench

Shares the single line-wide memory port between the instruction cache and the data cache of the 16-bit pipelined CPU. Each cache issues line fills (read) and dirty-line writebacks (write) as a held request. The arbiter grants one request at a time, drives the memory strobe and counts the fixed memory latency. It then returns read data and a one-cycle ack to the granted cache.

---
 rtl/cache_mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Purpose:
//   Shares the single line-wide memory port between the instruction cache and
//   the data cache. One request is granted at a time. The granted line address
//   and writeback data are registered, a one-cycle memory strobe is issued,
//   and the fixed memory latency is counted down. Read data is then captured
//   into the owner's rdata register, and the owner gets a one-cycle ack.
//
// Handshake:
//   A cache raises req_rd and/or req_wr and holds it, with addr/wdata, until it
//   sees its ack. It drops the request at the edge after the ack. A request
//   still high in the IDLE cycle after DONE counts as a new transaction.
//   addr and wdata are latched at grant, so later changes are ignored.
//   If both req_wr and req_rd are high on one side, the writeback is done.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   i_req_rd/i_req_wr        icache fill / writeback request (level, held)
//   i_addr, i_wdata          icache line address (bits[1:0] ignored), wb line
//   i_rdata, i_ack           fill data register, one-cycle completion pulse
//   d_*                      same set for the dcache
//   mem_read_m/mem_write_m   one-cycle memory strobes
//   mem_addr, mem_wdata      registered line address ([1:0]=00) and wb line
//   mem_rdata                memory read line
//   busy                     high in every state except IDLE
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate between
//                       the caches using rr_ptr. Otherwise the dcache always
//                       has priority.
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 64,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req_rd,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req_rd,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_read_m,
    output logic              mem_write_m,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The counter holds MEM_LATENCY-1 through ISSUE. It steps down once per
    // WAIT cycle, and capture happens at the edge where it reads 1. This puts
    // the capture edge MEM_LATENCY-1 cycles after the strobe cycle.
    localparam logic [3:0]        CNT_LOAD  = 4'(MEM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(3);

    // owner encoding: 1 = dcache, 0 = icache
    localparam logic OWNER_D = 1'b1;
    localparam logic OWNER_I = 1'b0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    logic              i_any;
    logic              d_any;
    logic              grant_d_side;
    logic              capture;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;
    logic              sel_wr;

    assign i_any = i_req_rd | i_req_wr;
    assign d_any = d_req_rd | d_req_wr;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_ptr: 1 = dcache wins a tie, 0 = icache wins a tie. After every
    // grant it points away from the side that was just served.
    logic rr_ptr_q, rr_ptr_d;

    assign grant_d_side = d_any & (~i_any | rr_ptr_q);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && (i_any || d_any)) begin
            rr_ptr_d = ~grant_d_side;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= OWNER_D;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: the dcache always wins a tie.
    assign grant_d_side = d_any;
`endif

    // Request fields of the side that would be granted this cycle
    assign sel_addr  = grant_d_side ? d_addr   : i_addr;
    assign sel_wdata = grant_d_side ? d_wdata  : i_wdata;
    assign sel_wr    = grant_d_side ? d_req_wr : i_req_wr;

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        op_wr_d     = op_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        capture     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_any || d_any) begin
                    owner_d     = grant_d_side ? OWNER_D : OWNER_I;
                    op_wr_d     = sel_wr;   // write wins when both are high
                    mem_addr_d  = sel_addr & LINE_MASK;
                    mem_wdata_d = sel_wdata;
                    cnt_d       = CNT_LOAD;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q != 4'd0) begin
                    state_d = WAIT;
                end else begin
                    // MEM_LATENCY == 1: data is ready at the end of the strobe cycle
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= 1 rather than == 1 so a corrupted count cannot hang here
                if (cnt_q <= 4'd1) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data goes only to the owner's register. Writes leave rdata untouched.
    always_comb begin
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (capture && !op_wr_q) begin
            if (owner_q == OWNER_D) begin
                d_rdata_d = mem_rdata;
            end else begin
                i_rdata_d = mem_rdata;
            end
        end
    end

    // State register. Reset drops any in-flight transaction without an ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= OWNER_D;
            op_wr_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            op_wr_q     <= op_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Outputs
    assign mem_read_m  = (state_q == ISSUE) && !op_wr_q;
    assign mem_write_m = (state_q == ISSUE) &&  op_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_ack       = (state_q == DONE) && (owner_q == OWNER_I);
    assign d_ack       = (state_q == DONE) && (owner_q == OWNER_D);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Two instances share one set of cache-side inputs: the main one with
// MEM_LATENCY=4 and a second one with MEM_LATENCY=1. The memory responder
// drives the correct line only in the capture cycle and random junk in every
// other cycle.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;
  localparam int LAT  = 4;
  localparam int LAT1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_req_rd, i_req_wr, d_req_rd, d_req_wr;
  logic [15:0] i_addr, d_addr;
  logic [63:0] i_wdata, d_wdata;

  logic [63:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_read_m, mem_write_m, busy;
  logic [15:0] mem_addr;

  logic [63:0] i_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic        i_ack1, d_ack1, mem_read_m1, mem_write_m1, busy1;
  logic [15:0] mem_addr1;

  cache_mem_arbiter #(.ADDR_W(16), .LINE_W(64), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_rd(i_req_rd), .i_req_wr(i_req_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req_rd(d_req_rd), .d_req_wr(d_req_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  cache_mem_arbiter #(.ADDR_W(16), .LINE_W(64), .MEM_LATENCY(LAT1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req_rd(i_req_rd), .i_req_wr(i_req_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req_rd(d_req_rd), .d_req_wr(d_req_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_read_m(mem_read_m1), .mem_write_m(mem_write_m1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // ---------------- memory contents and responder ----------------
  function automatic logic [63:0] mem_line(input logic [15:0] a);
    return {a ^ 16'hA5A5, a + 16'd3, ~a, a};
  endfunction

  int age0 = 99;
  int age1 = 99;
  always @(negedge clk) begin
    if (mem_read_m) age0 = 0; else if (age0 < 99) age0 = age0 + 1;
    if (age0 == LAT - 1) mem_rdata = mem_line(mem_addr);
    else mem_rdata = {$urandom, $urandom};
    if (mem_read_m1) age1 = 0; else if (age1 < 99) age1 = age1 + 1;
    if (age1 == LAT1 - 1) mem_rdata1 = mem_line(mem_addr1);
    else mem_rdata1 = {$urandom, $urandom};
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_rd = 0; i_req_wr = 0; d_req_rd = 0; d_req_wr = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
  endtask

  // Ends at posedge+1 of the first cycle with reset released.
  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    repeat (2) next_cycle();
    reset_n = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  req;   // {i_rd, i_wr, d_rd, d_wr}
    logic        busy, rd, wr, iack, dack;
    logic [15:0] maddr;
    logic [63:0] irdata, drdata;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] req, input logic b, input logic rd,
                              input logic wr, input logic ia, input logic da,
                              input logic [15:0] ma, input logic [63:0] ie,
                              input logic [63:0] de);
    vec_t v;
    v.req = req; v.busy = b; v.rd = rd; v.wr = wr; v.iack = ia; v.dack = da;
    v.maddr = ma; v.irdata = ie; v.drdata = de;
    return v;
  endfunction

  // ---------------- scoreboard: expected ack order ----------------
  logic [0:0] exp_q[$];   // owner of each granted transaction, 1 = dcache

  // ---------------- random-phase reference model ----------------
  int          cyc;
  bit          has_txn;
  bit          t_owner;   // 1 = dcache
  bit          t_wr;
  logic [15:0] t_addr;
  logic [63:0] t_wdata;
  int          grant_c, ack_c;
  logic [15:0] exp_maddr;
  logic [63:0] exp_mwdata;
  logic [63:0] exp_rdata[2];
  bit          rr;        // 1 = dcache wins a tie

  bit          req_on[2];
  int          gap[2];
  bit          ack_seen[2];
  int          op[2];     // 0 read, 1 write, 2 both
  logic [15:0] ra[2];
  logic [63:0] rw[2];

  task automatic model_cycle();
    bit any_i, any_d, pick_d;
    bit act;
    logic [0:0] o;
    // outputs expected for the current cycle
    act = has_txn && cyc > grant_c && cyc <= ack_c;
    if (has_txn && cyc == ack_c && !t_wr) exp_rdata[t_owner] = mem_line(t_addr);
    chk("rnd busy", busy, act);
    chk("rnd mem_read_m", mem_read_m, has_txn && cyc == grant_c + 1 && !t_wr);
    chk("rnd mem_write_m", mem_write_m, has_txn && cyc == grant_c + 1 && t_wr);
    chk("rnd i_ack", i_ack, has_txn && cyc == ack_c && !t_owner);
    chk("rnd d_ack", d_ack, has_txn && cyc == ack_c && t_owner);
    chk("rnd mem_addr", mem_addr, exp_maddr);
    chk("rnd mem_wdata", mem_wdata, exp_mwdata);
    chk("rnd i_rdata", i_rdata, exp_rdata[0]);
    chk("rnd d_rdata", d_rdata, exp_rdata[1]);
    // ack order scoreboard
    if (i_ack) begin
      if (exp_q.size() == 0) chk("rnd i_ack unexpected", 1, 0);
      else begin o = exp_q.pop_front(); chk("rnd ack owner", 0, o); end
    end
    if (d_ack) begin
      if (exp_q.size() == 0) chk("rnd d_ack unexpected", 1, 0);
      else begin o = exp_q.pop_front(); chk("rnd ack owner", 1, o); end
    end
    // arbitration decision taken in this cycle
    any_i = i_req_rd || i_req_wr;
    any_d = d_req_rd || d_req_wr;
    if ((!has_txn || cyc > ack_c) && (any_i || any_d)) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_d = any_d && (!any_i || rr);
      rr = !pick_d;
`else
      pick_d = any_d;
`endif
      has_txn    = 1;
      t_owner    = pick_d;
      t_wr       = pick_d ? d_req_wr : i_req_wr;
      t_addr     = (pick_d ? d_addr : i_addr) & 16'hFFFC;
      t_wdata    = pick_d ? d_wdata : i_wdata;
      grant_c    = cyc;
      ack_c      = cyc + LAT + 1;
      exp_maddr  = t_addr;
      exp_mwdata = t_wdata;
      exp_q.push_back(pick_d);
    end
    if (i_ack) ack_seen[0] = 1;
    if (d_ack) ack_seen[1] = 1;
  endtask

  task automatic drive_requesters();
    for (int s = 0; s < 2; s++) begin
      if (ack_seen[s]) begin
        req_on[s] = 0; ack_seen[s] = 0; gap[s] = $urandom_range(0, 3);
      end else if (!req_on[s]) begin
        if (gap[s] == 0) begin
          req_on[s] = 1;
          op[s] = $urandom_range(0, 2);
          ra[s] = 16'($urandom);
          rw[s] = {$urandom, $urandom};
        end else gap[s]--;
      end else if ($urandom_range(0, 3) == 0) begin
        ra[s] = 16'($urandom);
        rw[s] = {$urandom, $urandom};
      end
    end
    i_req_rd = req_on[0] && op[0] != 1;
    i_req_wr = req_on[0] && op[0] != 0;
    i_addr = ra[0]; i_wdata = rw[0];
    d_req_rd = req_on[1] && op[1] != 1;
    d_req_wr = req_on[1] && op[1] != 0;
    d_addr = ra[1]; d_wdata = rw[1];
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t tbl[20];
    logic [63:0] la, lb, l0120;

    // reset state of both instances
    reset_n = 0;
    idle_inputs();
    repeat (3) next_cycle();
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset strobes", {mem_read_m, mem_write_m}, 0);
    chk("reset acks", {i_ack, d_ack}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset i_rdata", i_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    chk("reset busy1", busy1, 0);
    chk("reset d_rdata1", d_rdata1, 0);

    // ---- single dcache read; the latency-1 instance re-issues while held ----
    l0120 = mem_line(16'h0120);
    do_reset();
    d_req_rd = 1; d_addr = 16'h0123;
    @(negedge clk);
    chk("rd c0 busy", busy, 0);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      if (k == 6) d_req_rd = 0;
      @(negedge clk);
      chk($sformatf("rd c%0d mem_read_m", k), mem_read_m, k == 1);
      chk($sformatf("rd c%0d mem_write_m", k), mem_write_m, 0);
      chk($sformatf("rd c%0d busy", k), busy, k <= 5);
      chk($sformatf("rd c%0d d_ack", k), d_ack, k == 5);
      chk($sformatf("rd c%0d i_ack", k), i_ack, 0);
      chk($sformatf("rd c%0d mem_addr", k), mem_addr, 16'h0120);
      chk($sformatf("rd c%0d d_rdata", k), d_rdata, (k >= 5) ? l0120 : 64'd0);
      chk($sformatf("lat1 c%0d mem_read_m", k), mem_read_m1, k == 1 || k == 4);
      chk($sformatf("lat1 c%0d d_ack", k), d_ack1, k == 2 || k == 5);
      chk($sformatf("lat1 c%0d busy", k), busy1, k == 1 || k == 2 || k == 4 || k == 5);
      if (k >= 2) chk($sformatf("lat1 c%0d d_rdata", k), d_rdata1, l0120);
    end

    // ---- single icache write; addr/wdata changes after grant are ignored ----
    next_cycle();
    i_req_wr = 1; i_addr = 16'h0F08; i_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    chk("wr c0 busy", busy, 0);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      if (k == 2) begin i_addr = 16'h7777; i_wdata = 64'h0123_4567_89AB_CDEF; end
      if (k == 6) i_req_wr = 0;
      @(negedge clk);
      chk($sformatf("wr c%0d mem_write_m", k), mem_write_m, k == 1);
      chk($sformatf("wr c%0d mem_read_m", k), mem_read_m, 0);
      chk($sformatf("wr c%0d i_ack", k), i_ack, k == 5);
      chk($sformatf("wr c%0d d_ack", k), d_ack, 0);
      chk($sformatf("wr c%0d mem_addr", k), mem_addr, 16'h0F08);
      chk($sformatf("wr c%0d mem_wdata", k), mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
      chk($sformatf("wr c%0d i_rdata", k), i_rdata, 0);
      chk($sformatf("wr c%0d d_rdata", k), d_rdata, l0120);
    end

    // ---- reset in cycle c3 of a read, request held through reset ----
    do_reset();
    d_req_rd = 1; d_addr = 16'h0046;
    next_cycle(); next_cycle(); next_cycle();
    reset_n = 0;            // asserted during c3
    next_cycle();
    reset_n = 1;            // c4 is idle and is the new c0
    @(negedge clk);
    chk("rst c4 busy", busy, 0);
    chk("rst c4 strobe", {mem_read_m, mem_write_m}, 0);
    chk("rst c4 d_ack", d_ack, 0);
    chk("rst c4 d_rdata", d_rdata, 0);
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("rst re%0d mem_read_m", k), mem_read_m, k == 1);
      chk($sformatf("rst re%0d d_ack", k), d_ack, k == 5);
      chk($sformatf("rst re%0d d_rdata", k), d_rdata,
          (k == 5) ? mem_line(16'h0044) : 64'd0);
    end

    // ---- table: simultaneous reads, then read+write on dcache ----
    la = mem_line(16'hFFFC);
    lb = mem_line(16'h1234);
    tbl[0]  = mk(4'b1010, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(4'b1010, 1, 1, 0, 0, 0, 16'hFFFC, 0, 0);
    tbl[2]  = mk(4'b1010, 1, 0, 0, 0, 0, 16'hFFFC, 0, 0);
    tbl[3]  = mk(4'b1010, 1, 0, 0, 0, 0, 16'hFFFC, 0, 0);
    tbl[4]  = mk(4'b1010, 1, 0, 0, 0, 0, 16'hFFFC, 0, 0);
    tbl[5]  = mk(4'b1010, 1, 0, 0, 0, 1, 16'hFFFC, 0, la);
    tbl[6]  = mk(4'b1000, 0, 0, 0, 0, 0, 16'hFFFC, 0, la);
    tbl[7]  = mk(4'b1000, 1, 1, 0, 0, 0, 16'h1234, 0, la);
    tbl[8]  = mk(4'b1000, 1, 0, 0, 0, 0, 16'h1234, 0, la);
    tbl[9]  = mk(4'b1000, 1, 0, 0, 0, 0, 16'h1234, 0, la);
    tbl[10] = mk(4'b1000, 1, 0, 0, 0, 0, 16'h1234, 0, la);
    tbl[11] = mk(4'b1000, 1, 0, 0, 1, 0, 16'h1234, lb, la);
    tbl[12] = mk(4'b0000, 0, 0, 0, 0, 0, 16'h1234, lb, la);
    tbl[13] = mk(4'b0011, 0, 0, 0, 0, 0, 16'h1234, lb, la);
    tbl[14] = mk(4'b0011, 1, 0, 1, 0, 0, 16'hFFFC, lb, la);
    tbl[15] = mk(4'b0011, 1, 0, 0, 0, 0, 16'hFFFC, lb, la);
    tbl[16] = mk(4'b0011, 1, 0, 0, 0, 0, 16'hFFFC, lb, la);
    tbl[17] = mk(4'b0011, 1, 0, 0, 0, 0, 16'hFFFC, lb, la);
    tbl[18] = mk(4'b0011, 1, 0, 0, 0, 1, 16'hFFFC, lb, la);
    tbl[19] = mk(4'b0000, 0, 0, 0, 0, 0, 16'hFFFC, lb, la);
    do_reset();
    i_addr = 16'h1235; d_addr = 16'hFFFF; d_wdata = 64'h1111_2222_3333_4444;
    for (int r = 0; r < 20; r++) begin
      if (r > 0) next_cycle();
      {i_req_rd, i_req_wr, d_req_rd, d_req_wr} = tbl[r].req;
      @(negedge clk);
      chk($sformatf("tbl r%0d busy", r), busy, tbl[r].busy);
      chk($sformatf("tbl r%0d mem_read_m", r), mem_read_m, tbl[r].rd);
      chk($sformatf("tbl r%0d mem_write_m", r), mem_write_m, tbl[r].wr);
      chk($sformatf("tbl r%0d i_ack", r), i_ack, tbl[r].iack);
      chk($sformatf("tbl r%0d d_ack", r), d_ack, tbl[r].dack);
      chk($sformatf("tbl r%0d mem_addr", r), mem_addr, tbl[r].maddr);
      chk($sformatf("tbl r%0d i_rdata", r), i_rdata, tbl[r].irdata);
      chk($sformatf("tbl r%0d d_rdata", r), d_rdata, tbl[r].drdata);
      if (tbl[r].wr) chk($sformatf("tbl r%0d mem_wdata", r), mem_wdata, d_wdata);
    end

    // ---- randomized traffic against the reference model ----
    do_reset();
    cyc = 0; has_txn = 0; grant_c = 0; ack_c = 0;
    exp_maddr = '0; exp_mwdata = '0; exp_rdata[0] = '0; exp_rdata[1] = '0;
    rr = 1; exp_q.delete();
    for (int s = 0; s < 2; s++) begin
      req_on[s] = 0; gap[s] = $urandom_range(0, 3); ack_seen[s] = 0;
      op[s] = 0; ra[s] = '0; rw[s] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) begin next_cycle(); cyc++; end
      drive_requesters();
      @(negedge clk);
      model_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
